// File: rtl/pulse_sweep.sv
// pulse_sweep: delay-sweep scheduler for the pulse generator.
// Steps the generator's delay word through del_start, del_start+del_step, ...
// and counts n_shots sequences (falling edges of sync) at each point.
// New delay values are applied only on a sync rise, so every pulse sequence
// is built from a single, consistent delay value.
module pulse_sweep #(
   parameter int DW = 16,
   parameter int NW = 8,
   parameter int SW = 16
) (
   input  logic          clk_pll,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] del_start,
   input  logic [DW-1:0] del_step,
   input  logic [NW-1:0] n_points,
   input  logic [SW-1:0] n_shots,
   input  logic          sync_in,
   output logic [DW-1:0] del_out,
   output logic [NW-1:0] point_idx,
   output logic [SW-1:0] shot_cnt,
   output logic          point_done,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_PEND,
      S_FINISH
   } state_t;

   state_t        state, state_n;
   logic          sync_q;
   logic          rise, fall;

   logic [DW-1:0] cfg_start, cfg_start_n;
   logic [DW-1:0] cfg_step, cfg_step_n;
   logic [NW-1:0] cfg_points, cfg_points_n;
   logic [SW-1:0] cfg_shots, cfg_shots_n;

   logic [DW-1:0] del_out_n;
   logic [NW-1:0] point_idx_n;
   logic [SW-1:0] shot_cnt_n;
   logic          point_done_n, busy_n, done_n, err_n;

   logic [DW:0]   del_sum;
   logic [SW-1:0] shot_inc;

   assign rise     = sync_in & ~sync_q;
   assign fall     = ~sync_in & sync_q;
   assign del_sum  = {1'b0, del_out} + {1'b0, cfg_step};
   assign shot_inc = shot_cnt + SW'(1);

   // Delayed copy of sync for edge detection.
   always_ff @(posedge clk_pll) begin
      if (reset) sync_q <= 1'b0;
      else       sync_q <= sync_in;
   end

   // State, captured configuration and all outputs are registered here.
   always_ff @(posedge clk_pll) begin
      if (reset) begin
         state      <= S_IDLE;
         cfg_start  <= '0;
         cfg_step   <= '0;
         cfg_points <= '0;
         cfg_shots  <= '0;
         del_out    <= '0;
         point_idx  <= '0;
         shot_cnt   <= '0;
         point_done <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         cfg_start  <= cfg_start_n;
         cfg_step   <= cfg_step_n;
         cfg_points <= cfg_points_n;
         cfg_shots  <= cfg_shots_n;
         del_out    <= del_out_n;
         point_idx  <= point_idx_n;
         shot_cnt   <= shot_cnt_n;
         point_done <= point_done_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
      end
   end

   // Next-state and next-output logic; abort has priority in every active state.
   always_comb begin
      state_n      = state;
      cfg_start_n  = cfg_start;
      cfg_step_n   = cfg_step;
      cfg_points_n = cfg_points;
      cfg_shots_n  = cfg_shots;
      del_out_n    = del_out;
      point_idx_n  = point_idx;
      shot_cnt_n   = shot_cnt;
      point_done_n = 1'b0;
      busy_n       = busy;
      done_n       = 1'b0;
      err_n        = err;

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               cfg_start_n  = del_start;
               cfg_step_n   = del_step;
               cfg_points_n = n_points;
               cfg_shots_n  = n_shots;
               err_n        = 1'b0;
               if (n_points == '0 || n_shots == '0) begin
                  err_n  = 1'b1;
                  done_n = 1'b1;
               end else begin
                  busy_n  = 1'b1;
                  state_n = S_ARM;
               end
            end
         end

         S_ARM: begin
            if (abort) begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else if (rise) begin
               del_out_n   = cfg_start;
               point_idx_n = '0;
               shot_cnt_n  = '0;
               state_n     = S_RUN;
            end
         end

         S_RUN: begin
            if (abort) begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else if (fall) begin
               shot_cnt_n = shot_inc;
               if (shot_inc == cfg_shots) begin
                  point_done_n = 1'b1;
                  if (point_idx == cfg_points - NW'(1)) begin
                     state_n = S_FINISH;
                  end else if (del_sum[DW]) begin
                     err_n   = 1'b1;
                     state_n = S_FINISH;
                  end else begin
                     state_n = S_PEND;
                  end
               end
            end
         end

         S_PEND: begin
            if (abort) begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else if (rise) begin
               del_out_n   = del_sum[DW-1:0];
               point_idx_n = point_idx + NW'(1);
               shot_cnt_n  = '0;
               state_n     = S_RUN;
            end
         end

         S_FINISH: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
            if (!abort) done_n = 1'b1;
         end

         default: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

endmodule
